instr_mem_sync: RTL and testbench

- Parametrised, clocked successor to the combinational instruction ROM. It is a word-addressed RAM that is cleared to NOP after reset, programmable at run time through a write port, and read through a one-cycle-latency fetch port with a stall hold.
- Faults are flagged for misaligned and out-of-range fetches. It sits between the PC/fetch stage and the decode stage of the single-cycle/pipelined CPU.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/imem_array.sv | 29 ++
 rtl/instr_mem_sync.sv | 113 +++++++++++
 tb/tb_instr_mem_sync.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default NOP encoding, instruction-memory FSM
// states and the opcode/funct constants used by decode.
package cpu_pkg;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } imem_state_t;

  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_RTYPE   = 6'b000000;
  localparam logic [5:0] FUNCT_MUL  = 6'b011000;

endpackage

// File: rtl/imem_array.sv
// DEPTH x DATA_W RAM, one synchronous write port, one synchronous read port.
// A read and a write to the same word in one cycle return the old contents.
// Ports: clk; i_we/i_waddr/i_wdata write port; i_re/i_raddr read request;
// o_rdata read data, updated only on cycles with i_re=1.
module imem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];  // samples pre-write value
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_sync.sv
// Clocked instruction memory: cleared to NOP after reset, programmable at
// run time, one-cycle-latency fetch port with stall hold and fault flags.
// Ports: clk, rst (sync, active high); fetch_req/fetch_addr/fetch_ready
// request side; instr_hold stall; instr/instr_valid/fault_misaligned/
// fault_range response; prog_we/prog_addr/prog_data write port; prog_err
// one-cycle rejection pulse.
module instr_mem_sync
  import cpu_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              ADDR_W   = 32,
  parameter int              DEPTH    = 64,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  input  logic              instr_hold,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              fault_misaligned,
  output logic              fault_range,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_err
);

  localparam int AW = $clog2(DEPTH);

  imem_state_t r_state, w_state_nxt;
  logic [AW-1:0] r_cnt, w_cnt_nxt;

  logic r_valid, r_fmis, r_frng, r_use_nop, r_prog_err;

  // Anything at or above DEPTH*4 has a nonzero bit above the word index.
  logic w_f_mis, w_f_rng, w_accept;
  logic w_p_ok, w_p_rej;
  logic w_we;
  logic [AW-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata, w_rdata;

  assign fetch_ready = (r_state == RUN);
  assign w_f_mis  = (fetch_addr[1:0] != 2'b00);
  assign w_f_rng  = ((fetch_addr >> (AW + 2)) != '0);
  assign w_accept = fetch_req && fetch_ready && !instr_hold;

  assign w_p_ok  = (prog_addr[1:0] == 2'b00) && ((prog_addr >> (AW + 2)) == '0);
  assign w_p_rej = prog_we && ((r_state == CLEAR) || !w_p_ok);

  // CLEAR owns the write port; in RUN only legal program writes reach it.
  assign w_we    = !rst && ((r_state == CLEAR) || (prog_we && w_p_ok));
  assign w_waddr = (r_state == CLEAR) ? r_cnt : prog_addr[AW+1:2];
  assign w_wdata = (r_state == CLEAR) ? NOP_WORD : prog_data;

  imem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_accept),
    .i_raddr (fetch_addr[AW+1:2]),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_state == CLEAR) begin
      w_cnt_nxt = r_cnt + AW'(1);
      if (r_cnt == AW'(DEPTH - 1)) w_state_nxt = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The RAM read register only advances on accepted fetches, so it and
  // r_use_nop together hold the last response across idle and stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_fmis     <= 1'b0;
      r_frng     <= 1'b0;
      r_use_nop  <= 1'b1;
      r_prog_err <= 1'b0;
    end else begin
      r_prog_err <= w_p_rej;
      if (!instr_hold) begin
        r_valid <= w_accept;
        r_fmis  <= w_accept && w_f_mis;
        r_frng  <= w_accept && w_f_rng;
        if (w_accept) r_use_nop <= w_f_mis || w_f_rng;
      end
    end
  end

  assign instr            = r_use_nop ? NOP_WORD : w_rdata;
  assign instr_valid      = r_valid;
  assign fault_misaligned = r_fmis;
  assign fault_range      = r_frng;
  assign prog_err         = r_prog_err;

endmodule

// File: tb/tb_instr_mem_sync.sv
module tb_instr_mem_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        instr_hold;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fault_misaligned;
  logic        fault_range;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic        prog_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_mem_sync #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .NOP_WORD(32'h0)) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_req        (fetch_req),
    .fetch_addr       (fetch_addr),
    .fetch_ready      (fetch_ready),
    .instr_hold       (instr_hold),
    .instr            (instr),
    .instr_valid      (instr_valid),
    .fault_misaligned (fault_misaligned),
    .fault_range      (fault_range),
    .prog_we          (prog_we),
    .prog_addr        (prog_addr),
    .prog_data        (prog_data),
    .prog_err         (prog_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // advance one edge, then settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resp(input string tag, input logic [31:0] ei, input logic ev,
                      input logic em, input logic er);
    chk({tag, ".instr"}, 64'(instr), 64'(ei));
    chk({tag, ".valid"}, 64'(instr_valid), 64'(ev));
    chk({tag, ".fmis"}, 64'(fault_misaligned), 64'(em));
    chk({tag, ".frng"}, 64'(fault_range), 64'(er));
  endtask

  task automatic prog(input logic [31:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_req = 1'b1; fetch_addr = a;
    tick();
    fetch_req = 1'b0;
  endtask

  // counts cycles with fetch_ready low after the reset edge; optionally
  // issues a program write during the first CLEAR cycle
  task automatic do_reset(input string tag, input logic prog_in_clear);
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    resp({tag, ".rst"}, 32'h0, 1'b0, 1'b0, 1'b0);
    chk({tag, ".rst.ready"}, 64'(fetch_ready), 64'd0);
    chk({tag, ".rst.perr"}, 64'(prog_err), 64'd0);
    if (prog_in_clear) begin
      prog_we = 1'b1; prog_addr = 32'h0; prog_data = 32'hFFFF_FFFF;
    end
    n = 0;
    while (!fetch_ready && n < 200) begin
      n++;
      tick();
      if (n == 1 && prog_in_clear) begin
        prog_we = 1'b0;
        chk({tag, ".clear_perr"}, 64'(prog_err), 64'd1);
      end
    end
    chk({tag, ".clear_cycles"}, 64'(n), 64'd64);
  endtask

  initial begin
    rst = 1'b0; fetch_req = 1'b0; fetch_addr = '0; instr_hold = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    #2;

    do_reset("r1", 1'b0);
    fetch(32'd0);
    resp("idle0", 32'h0, 1'b1, 1'b0, 1'b0);

    prog(32'd0, 32'h2108_00D5);
    chk("p0.perr", 64'(prog_err), 64'd0);
    prog(32'd4, 32'h2129_003C);
    prog(32'd8, 32'h214A_0009);

    // back-to-back fetches
    fetch_req = 1'b1; fetch_addr = 32'd0; tick();
    resp("b2b0", 32'h2108_00D5, 1'b1, 1'b0, 1'b0);
    fetch_addr = 32'd4; tick();
    resp("b2b4", 32'h2129_003C, 1'b1, 1'b0, 1'b0);
    fetch_addr = 32'd8; tick();
    resp("b2b8", 32'h214A_0009, 1'b1, 1'b0, 1'b0);
    fetch_req = 1'b0; tick();
    resp("idle_keep", 32'h214A_0009, 1'b0, 1'b0, 1'b0);

    // faults
    fetch(32'd6);
    resp("mis6", 32'h0, 1'b1, 1'b1, 1'b0);
    fetch(32'd256);
    resp("rng256", 32'h0, 1'b1, 1'b0, 1'b1);
    fetch(32'd258);
    resp("both258", 32'h0, 1'b1, 1'b1, 1'b1);
    prog(32'd257, 32'hDEAD_BEEF);
    chk("p257.perr", 64'(prog_err), 64'd1);
    tick();
    chk("p257.pulse_end", 64'(prog_err), 64'd0);
    fetch(32'd0);
    resp("p257.mem0", 32'h2108_00D5, 1'b1, 1'b0, 1'b0);

    // read-before-write collision
    prog(32'd12, 32'h1211_0002);
    prog_we = 1'b1; prog_addr = 32'd12; prog_data = 32'h0800_0007;
    fetch_req = 1'b1; fetch_addr = 32'd12;
    tick();
    prog_we = 1'b0;
    resp("coll.old", 32'h1211_0002, 1'b1, 1'b0, 1'b0);
    tick();
    fetch_req = 1'b0;
    resp("coll.new", 32'h0800_0007, 1'b1, 1'b0, 1'b0);

    // stall: response to addr 8 frozen while requests toggle
    fetch(32'd8);
    resp("stall.pre", 32'h214A_0009, 1'b1, 1'b0, 1'b0);
    instr_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_req = (i != 1); fetch_addr = 32'd6;
      tick();
      resp($sformatf("stall%0d", i), 32'h214A_0009, 1'b1, 1'b0, 1'b0);
    end
    instr_hold = 1'b0;
    fetch(32'd4);
    resp("stall.rel", 32'h2129_003C, 1'b1, 1'b0, 1'b0);

    // reset during RUN, with a write attempted in CLEAR
    do_reset("r2", 1'b1);
    fetch(32'd0);
    resp("r2.mem0", 32'h0, 1'b1, 1'b0, 1'b0);
    fetch(32'd4);
    resp("r2.mem1", 32'h0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
